ysyx_23060077_icache_axi_rd: RTL and testbench

- Responder end of the Icache refill read interface (`Icache_r_*`).
- Accepts one burst read request from the Icache and issues it as a single AXI4 read burst.
- Returns each data beat to the Icache as a one-cycle `ready` pulse, with `last` on the final beat.
- Sits between the Icache and the SoC AXI crossbar. Read-only; no write channels.

---
 rtl/ysyx_23060077_icache_axi_rd.sv | 105 ++++++++++
 tb/tb_ysyx_23060077_icache_axi_rd.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060077_icache_axi_rd.sv
// Icache refill read bridge: turns one Icache burst request into a single AXI4
// INCR read burst and returns each beat as a one-cycle ready pulse.
module ysyx_23060077_icache_axi_rd #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 8,
   parameter int AXI_ID = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              Icache_r_valid_i,
   input  logic [ADDR_W-1:0] Icache_r_addr_i,
   input  logic [LEN_W-1:0]  Icache_r_len_i,
   output logic              Icache_r_ready_o,
   output logic [DATA_W-1:0] Icache_r_data_o,
   output logic              Icache_r_last_o,
   output logic              axi_arvalid_o,
   input  logic              axi_arready_i,
   output logic [ADDR_W-1:0] axi_araddr_o,
   output logic [3:0]        axi_arid_o,
   output logic [LEN_W-1:0]  axi_arlen_o,
   output logic [2:0]        axi_arsize_o,
   output logic [1:0]        axi_arburst_o,
   input  logic              axi_rvalid_i,
   output logic              axi_rready_o,
   input  logic [DATA_W-1:0] axi_rdata_i,
   input  logic [1:0]        axi_rresp_i,
   input  logic              axi_rlast_i,
   input  logic [3:0]        axi_rid_i,
   output logic              err_o
);

   typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;

   state_t           state;
   logic [LEN_W:0]   cnt;
   logic             final_beat;
   logic             beat_err;
   logic             beat;

   assign axi_arid_o    = 4'(AXI_ID);
   assign axi_arsize_o  = 3'b010;
   assign axi_arburst_o = 2'b01;

   // arlen_o doubles as the latched burst length; an rlast that disagrees
   // with the counter covers both early and missing termination.
   always_comb begin
      final_beat = (cnt == {1'b0, axi_arlen_o});
      beat       = axi_rvalid_i && axi_rready_o;
      beat_err   = (axi_rresp_i != 2'b00) || (axi_rid_i != 4'(AXI_ID)) ||
                   (axi_rlast_i != final_beat);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state            <= IDLE;
         cnt              <= '0;
         axi_arvalid_o    <= 1'b0;
         axi_araddr_o     <= '0;
         axi_arlen_o      <= '0;
         axi_rready_o     <= 1'b0;
         Icache_r_ready_o <= 1'b0;
         Icache_r_data_o  <= '0;
         Icache_r_last_o  <= 1'b0;
         err_o            <= 1'b0;
      end else begin
         Icache_r_ready_o <= 1'b0;
         Icache_r_last_o  <= 1'b0;
         case (state)
            IDLE: begin
               if (Icache_r_valid_i) begin
                  axi_araddr_o  <= Icache_r_addr_i & {{(ADDR_W-2){1'b1}}, 2'b00};
                  axi_arlen_o   <= Icache_r_len_i;
                  cnt           <= '0;
                  axi_arvalid_o <= 1'b1;
                  state         <= AR;
               end
            end
            AR: begin
               if (axi_arready_i) begin
                  axi_arvalid_o <= 1'b0;
                  axi_rready_o  <= 1'b1;
                  state         <= R;
               end
            end
            R: begin
               if (beat) begin
                  Icache_r_data_o  <= axi_rdata_i;
                  Icache_r_ready_o <= 1'b1;
                  Icache_r_last_o  <= final_beat || axi_rlast_i;
                  cnt              <= cnt + 1'b1;
                  if (beat_err) err_o <= 1'b1;
                  if (final_beat || axi_rlast_i) begin
                     axi_rready_o <= 1'b0;
                     state        <= DONE;
                  end
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_23060077_icache_axi_rd.sv
// Bench for the Icache refill read bridge: a directed burst table, hand-written
// reset sequences and randomized bursts, checked against a burst-level model.
module tb_ysyx_23060077_icache_axi_rd;

   logic        clock;
   logic        reset;
   logic        Icache_r_valid_i;
   logic [31:0] Icache_r_addr_i;
   logic [7:0]  Icache_r_len_i;
   logic        Icache_r_ready_o;
   logic [31:0] Icache_r_data_o;
   logic        Icache_r_last_o;
   logic        axi_arvalid_o;
   logic        axi_arready_i;
   logic [31:0] axi_araddr_o;
   logic [3:0]  axi_arid_o;
   logic [7:0]  axi_arlen_o;
   logic [2:0]  axi_arsize_o;
   logic [1:0]  axi_arburst_o;
   logic        axi_rvalid_i;
   logic        axi_rready_o;
   logic [31:0] axi_rdata_i;
   logic [1:0]  axi_rresp_i;
   logic        axi_rlast_i;
   logic [3:0]  axi_rid_i;
   logic        err_o;

   int checks = 0;
   int errors = 0;
   bit err_exp = 1'b0;

   ysyx_23060077_icache_axi_rd #(
      .ADDR_W(32),
      .DATA_W(32),
      .LEN_W (8),
      .AXI_ID(0)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .Icache_r_valid_i(Icache_r_valid_i),
      .Icache_r_addr_i (Icache_r_addr_i),
      .Icache_r_len_i  (Icache_r_len_i),
      .Icache_r_ready_o(Icache_r_ready_o),
      .Icache_r_data_o (Icache_r_data_o),
      .Icache_r_last_o (Icache_r_last_o),
      .axi_arvalid_o   (axi_arvalid_o),
      .axi_arready_i   (axi_arready_i),
      .axi_araddr_o    (axi_araddr_o),
      .axi_arid_o      (axi_arid_o),
      .axi_arlen_o     (axi_arlen_o),
      .axi_arsize_o    (axi_arsize_o),
      .axi_arburst_o   (axi_arburst_o),
      .axi_rvalid_i    (axi_rvalid_i),
      .axi_rready_o    (axi_rready_o),
      .axi_rdata_i     (axi_rdata_i),
      .axi_rresp_i     (axi_rresp_i),
      .axi_rlast_i     (axi_rlast_i),
      .axi_rid_i       (axi_rid_i),
      .err_o           (err_o)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  len;
      int          delay;
      logic [6:0]  gap7;
      int          early_at;
      int          resp_at;
      int          rid_at;
      bit          drop_last;
      bit          keep_valid;
      logic [31:0] step;
      logic [31:0] exp_araddr;
      int          exp_beats;
      bit          exp_err;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_arvalid"}, {31'd0, axi_arvalid_o}, 32'd0);
      chk({tag, "_araddr"}, axi_araddr_o, 32'd0);
      chk({tag, "_arlen"}, {24'd0, axi_arlen_o}, 32'd0);
      chk({tag, "_rready"}, {31'd0, axi_rready_o}, 32'd0);
      chk({tag, "_ready"}, {31'd0, Icache_r_ready_o}, 32'd0);
      chk({tag, "_data"}, Icache_r_data_o, 32'd0);
      chk({tag, "_last"}, {31'd0, Icache_r_last_o}, 32'd0);
      chk({tag, "_err"}, {31'd0, err_o}, 32'd0);
   endtask

   // Drives one full burst as Icache requester and AXI slave; the expected
   // pulse stream follows from the beats offered and the error rules alone.
   task automatic run_burst(input logic [31:0] a, input logic [7:0] l, input int delay,
                            input logic [6:0] gap7, input int early_at, input int resp_at,
                            input int rid_at, input bit drop_last, input bit keep_valid,
                            input logic [31:0] step, output logic [31:0] got_addr,
                            output int nbeats);
      int          i;
      int          slot;
      bit          done;
      bit          exp_last;
      logic [31:0] exp_data;
      i = 0; slot = 0; done = 1'b0; nbeats = 0;
      Icache_r_valid_i = 1'b1;
      Icache_r_addr_i  = a;
      Icache_r_len_i   = l;
      @(negedge clock);
      got_addr = axi_araddr_o;
      chk("arvalid_rise", {31'd0, axi_arvalid_o}, 32'd1);
      chk("arlen", {24'd0, axi_arlen_o}, {24'd0, l});
      chk("arid", {28'd0, axi_arid_o}, 32'd0);
      chk("arsize", {29'd0, axi_arsize_o}, 32'd2);
      chk("arburst", {30'd0, axi_arburst_o}, 32'd1);
      for (int k = 0; k < delay; k++) begin
         @(negedge clock);
         chk("arvalid_hold", {31'd0, axi_arvalid_o}, 32'd1);
         chk("araddr_hold", axi_araddr_o, got_addr);
      end
      axi_arready_i = 1'b1;
      @(negedge clock);
      axi_arready_i = 1'b0;
      chk("arvalid_drop", {31'd0, axi_arvalid_o}, 32'd0);
      while (!done && slot < 200) begin
         if (gap7[slot % 7]) begin
            chk("rready_r", {31'd0, axi_rready_o}, 32'd1);
            axi_rvalid_i = 1'b1;
            axi_rdata_i  = (step != 0) ? step * (i + 1) : $urandom;
            axi_rresp_i  = (i == resp_at) ? 2'b10 : 2'b00;
            axi_rid_i    = (i == rid_at) ? 4'h5 : 4'h0;
            axi_rlast_i  = (i == early_at) || (i == int'(l) && !drop_last);
            exp_last     = (i == int'(l)) || axi_rlast_i;
            exp_data     = axi_rdata_i;
            if (axi_rresp_i != 2'b00 || axi_rid_i != 4'h0 ||
                (axi_rlast_i && i < int'(l)) || (!axi_rlast_i && i == int'(l)))
               err_exp = 1'b1;
            @(negedge clock);
            axi_rvalid_i = 1'b0; axi_rlast_i = 1'b0;
            axi_rresp_i  = 2'b00; axi_rid_i = 4'h0;
            chk("beat_ready", {31'd0, Icache_r_ready_o}, 32'd1);
            chk("beat_data", Icache_r_data_o, exp_data);
            chk("beat_last", {31'd0, Icache_r_last_o}, {31'd0, exp_last});
            chk("beat_err", {31'd0, err_o}, {31'd0, err_exp});
            nbeats++; i++;
            done = exp_last;
         end else begin
            axi_rvalid_i = 1'b0;
            @(negedge clock);
            chk("gap_ready", {31'd0, Icache_r_ready_o}, 32'd0);
         end
         slot++;
      end
      // One cycle after the final pulse: rready must be down, a stray beat ignored.
      chk("done_rready", {31'd0, axi_rready_o}, 32'd0);
      if (!keep_valid) Icache_r_valid_i = 1'b0;
      axi_rvalid_i = 1'b1; axi_rdata_i = 32'hDEAD_BEEF;
      @(negedge clock);
      axi_rvalid_i = 1'b0;
      chk("stray_ready", {31'd0, Icache_r_ready_o}, 32'd0);
      chk("done_no_ar", {31'd0, axi_arvalid_o}, 32'd0);
      @(negedge clock);
      chk("idle_ready", {31'd0, Icache_r_ready_o}, 32'd0);
      if (keep_valid) begin
         chk("retrigger_ar", {31'd0, axi_arvalid_o}, 32'd1);
         chk("retrigger_addr", axi_araddr_o, got_addr);
         Icache_r_valid_i = 1'b0;
         axi_arready_i = 1'b1;
         @(negedge clock);
         axi_arready_i = 1'b0;
         axi_rvalid_i = 1'b1; axi_rdata_i = 32'h5A5A_0001; axi_rlast_i = 1'b1;
         @(negedge clock);
         axi_rvalid_i = 1'b0; axi_rlast_i = 1'b0;
         chk("retrigger_beat", Icache_r_data_o, 32'h5A5A_0001);
         @(negedge clock);
         @(negedge clock);
      end else begin
         chk("idle_no_ar", {31'd0, axi_arvalid_o}, 32'd0);
      end
   endtask

   vec_t        tbl[8];
   logic [31:0] got_addr;
   int          nbeats;

   initial begin
      tbl[0] = '{32'h3000_0010, 8'd3, 2, 7'h7F, -1, -1, -1, 1'b0, 1'b0, 32'h11,
                 32'h3000_0010, 4, 1'b0};
      tbl[1] = '{32'h8000_0003, 8'd0, 0, 7'h7F, -1, -1, -1, 1'b0, 1'b1, 32'h0,
                 32'h8000_0000, 1, 1'b0};
      tbl[2] = '{32'h4000_0104, 8'd7, 1, 7'b1001101, -1, -1, -1, 1'b0, 1'b0, 32'h0,
                 32'h4000_0104, 8, 1'b0};
      tbl[3] = '{32'h2000_0000, 8'd3, 0, 7'h7F, 1, -1, -1, 1'b0, 1'b0, 32'h0,
                 32'h2000_0000, 2, 1'b1};
      tbl[4] = '{32'h2000_0040, 8'd1, 0, 7'h7F, -1, 1, -1, 1'b0, 1'b0, 32'h0,
                 32'h2000_0040, 2, 1'b1};
      tbl[5] = '{32'h2000_0080, 8'd2, 3, 7'b0010101, -1, -1, -1, 1'b0, 1'b0, 32'h0,
                 32'h2000_0080, 3, 1'b1};
      tbl[6] = '{32'h2000_00C2, 8'd2, 0, 7'h7F, -1, -1, -1, 1'b1, 1'b0, 32'h0,
                 32'h2000_00C0, 3, 1'b1};
      tbl[7] = '{32'h2000_0101, 8'd1, 0, 7'h7F, -1, -1, 0, 1'b0, 1'b0, 32'h0,
                 32'h2000_0100, 2, 1'b1};

      reset = 1'b0;
      Icache_r_valid_i = 1'b0; Icache_r_addr_i = '0; Icache_r_len_i = '0;
      axi_arready_i = 1'b0; axi_rvalid_i = 1'b0; axi_rdata_i = '0;
      axi_rresp_i = 2'b00; axi_rlast_i = 1'b0; axi_rid_i = 4'h0;
      repeat (3) @(negedge clock);
      chk_all_zero("reset");
      reset = 1'b1;
      @(negedge clock);

      // Reset asserted while a beat is being delivered and err is set.
      Icache_r_valid_i = 1'b1; Icache_r_addr_i = 32'h1000_0008; Icache_r_len_i = 8'd3;
      @(negedge clock);
      chk("mr_arvalid", {31'd0, axi_arvalid_o}, 32'd1);
      axi_arready_i = 1'b1;
      @(negedge clock);
      axi_arready_i = 1'b0;
      chk("mr_rready", {31'd0, axi_rready_o}, 32'd1);
      axi_rvalid_i = 1'b1; axi_rdata_i = 32'h0000_00AB; axi_rresp_i = 2'b10;
      @(posedge clock);
      #2;
      chk("mr_pre_ready", {31'd0, Icache_r_ready_o}, 32'd1);
      chk("mr_pre_err", {31'd0, err_o}, 32'd1);
      reset = 1'b0;
      #1;
      chk_all_zero("mid_r_reset");
      @(negedge clock);
      chk_all_zero("mid_r_hold");
      axi_rvalid_i = 1'b0; axi_rresp_i = 2'b00; Icache_r_valid_i = 1'b0;
      reset = 1'b1;
      err_exp = 1'b0;
      @(negedge clock);
      chk("post_reset_idle", {31'd0, axi_arvalid_o}, 32'd0);
      run_burst(32'h1000_0020, 8'd2, 0, 7'h7F, -1, -1, -1, 1'b0, 1'b0, 32'h0, got_addr, nbeats);
      chk("post_reset_addr", got_addr, 32'h1000_0020);
      chk("post_reset_beats", nbeats, 32'd3);

      for (int n = 0; n < 8; n++) begin
         run_burst(tbl[n].addr, tbl[n].len, tbl[n].delay, tbl[n].gap7, tbl[n].early_at,
                   tbl[n].resp_at, tbl[n].rid_at, tbl[n].drop_last, tbl[n].keep_valid,
                   tbl[n].step, got_addr, nbeats);
         chk($sformatf("tbl%0d_araddr", n), got_addr, tbl[n].exp_araddr);
         chk($sformatf("tbl%0d_beats", n), nbeats, tbl[n].exp_beats);
         chk($sformatf("tbl%0d_err", n), {31'd0, err_o}, {31'd0, tbl[n].exp_err});
      end

      for (int n = 0; n < 40; n++) begin
         logic [31:0] a;
         logic [7:0]  l;
         int          early_at;
         int          resp_at;
         int          rid_at;
         int          exp_beats;
         a        = $urandom;
         l        = 8'($urandom_range(0, 15));
         early_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 32'(l))) : -1;
         resp_at  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 32'(l))) : -1;
         rid_at   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 32'(l))) : -1;
         exp_beats = (early_at >= 0 && early_at < int'(l)) ? early_at + 1 : int'(l) + 1;
         run_burst(a, l, int'($urandom_range(0, 3)), 7'($urandom) | 7'h01, early_at,
                   resp_at, rid_at, ($urandom_range(0, 7) == 0), 1'b0, 32'h0,
                   got_addr, nbeats);
         chk("rnd_araddr", got_addr, a & 32'hFFFF_FFFC);
         chk("rnd_beats", nbeats, exp_beats);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
